vga_pixel_streamer: RTL and testbench

// - Video transmitter: generates hsync/vsync/rgb for the racing-game display path, i.e. the stream a frame-logging bench decodes.
// - Pixel clock is clk/PIX_DIV. Pixel data comes from a framebuffer/renderer via a req/ack fetch one pixel ahead.
// - Output sync and rgb are registered and aligned; rgb is forced to 0 in blanking.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_pix_tick.sv | 32 +++
 rtl/vga_pixel_streamer.sv | 180 ++++++++++++++++++
 tb/tb_vga_pixel_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and types for the VGA pixel streamer.
// Contents:
//   *_DEF        default porch/sync/visible sizes (pixels, lines)
//   coord_x_t    9-bit column (also wide enough for the full line count 0..308)
//   coord_y_t    8-bit visible row as presented on the fetch interface
//   line_cnt_t   9-bit internal line counter (frame is 262 lines)
//   fetch_state_e  pixel fetch FSM states
package vga_timing_pkg;

  localparam int H_DISP_DEF = 256;
  localparam int H_FP_DEF   = 7;
  localparam int H_SYNC_DEF = 23;
  localparam int H_BP_DEF   = 23;

  localparam int V_DISP_DEF = 240;
  localparam int V_FP_DEF   = 14;
  localparam int V_SYNC_DEF = 3;
  localparam int V_BP_DEF   = 5;

  typedef logic [8:0] coord_x_t;
  typedef logic [7:0] coord_y_t;
  typedef logic [8:0] line_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HAVE
  } fetch_state_e;

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider. div counts 0..PIX_DIV-1; tick is high for the one clk
// in which div sits at PIX_DIV-1, so h/v advance once every PIX_DIV clks.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   tick   out  pixel tick, one clk wide
module vga_pix_tick #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_pixel_streamer.sv
// VGA transmitter: raster counters, one-pixel-ahead fetch FSM and the
// registered hsync/vsync/rgb output stage.
//
// Fetch FSM states:
//   state | meaning
//   IDLE  | no fetch outstanding (blanking, or the first pixel after reset)
//   WAIT  | pix_req issued, waiting for pix_ack before the next tick
//   HAVE  | pixel colour latched, emitted on the next tick
//
// Ports:
//   clk, reset        system clock, async active-low reset
//   pix_req           one-clk fetch request for (req_x, req_y)
//   req_x, req_y      requested visible coordinate
//   pix_ack, pix_rgb  fetch response; pix_rgb valid when pix_ack=1
//   clr_underrun      clears the sticky underrun flag
//   underrun          sticky: a fetch missed its deadline
//   hsync, vsync      active-low sync, idle high
//   rgb               pixel colour, 0 outside the visible area
//   frame_start       one-clk pulse when pixel (0,0) reaches the outputs
//   frame_cnt         frames started since reset, wraps
module vga_pixel_streamer
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int PIX_DIV = 2,
  parameter int RGB_W   = 3,
  parameter logic [RGB_W-1:0] UNDERRUN_RGB = '1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_req,
  output coord_x_t         req_x,
  output coord_y_t         req_y,
  input  logic             pix_ack,
  input  logic [RGB_W-1:0] pix_rgb,
  input  logic             clr_underrun,
  output logic             underrun,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam coord_x_t  H_VIS_END  = coord_x_t'(H_DISP);
  localparam coord_x_t  H_SYNC_BEG = coord_x_t'(H_DISP + H_FP);
  localparam coord_x_t  H_SYNC_END = coord_x_t'(H_DISP + H_FP + H_SYNC);
  localparam coord_x_t  H_LAST     = coord_x_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam line_cnt_t V_VIS_END  = line_cnt_t'(V_DISP);
  localparam line_cnt_t V_SYNC_BEG = line_cnt_t'(V_DISP + V_FP);
  localparam line_cnt_t V_SYNC_END = line_cnt_t'(V_DISP + V_FP + V_SYNC);
  localparam line_cnt_t V_LAST     = line_cnt_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);

  logic         tick;
  coord_x_t     h_cnt, h_nxt;
  line_cnt_t    v_cnt, v_nxt;
  logic         cur_vis, nxt_vis, h_in_sync, v_in_sync;

  fetch_state_e     state, state_nxt;
  logic [RGB_W-1:0] held, rgb_nxt;
  logic             miss, issue, take;

  vga_pix_tick #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    h_nxt = h_cnt + 9'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 9'd1;
    end
  end

  assign cur_vis   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign nxt_vis   = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The ack must land strictly before the tick that consumes the pixel: an
  // ack in the tick clk itself is late and ignored, because the same edge
  // already launches the fetch for the following pixel. A visible tick seen
  // in IDLE only happens for the first pixel after reset (nothing could be
  // fetched ahead of it); it is emitted as black and is not an underrun.
  always_comb begin
    state_nxt = state;
    rgb_nxt   = '0;
    miss      = 1'b0;
    issue     = 1'b0;
    take      = 1'b0;
    if (tick) begin
      if (cur_vis) begin
        case (state)
          HAVE:    rgb_nxt = held;
          WAIT: begin
            rgb_nxt = UNDERRUN_RGB;
            miss    = 1'b1;
          end
          default: rgb_nxt = '0;
        endcase
      end
      issue     = nxt_vis;
      state_nxt = nxt_vis ? WAIT : IDLE;
    end else if ((state == WAIT) && pix_ack) begin
      take      = 1'b1;
      state_nxt = HAVE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_req     <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      held        <= '0;
      underrun    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_req     <= issue;
      frame_start <= 1'b0;
      if (issue) begin
        req_x <= h_nxt;
        req_y <= coord_y_t'(v_nxt);
      end
      if (take) begin
        held <= pix_rgb;
      end
      // a new miss outranks a simultaneous clear
      if (miss) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
      if (tick) begin
        hsync <= !h_in_sync;
        vsync <= !v_in_sync;
        rgb   <= rgb_nxt;
        if ((h_cnt == '0) && (v_cnt == '0)) begin
          frame_start <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Directed bench for vga_pixel_streamer. A full-size instance covers line
// timing, the pixel pattern, underrun handling and mid-frame reset; a
// reduced-geometry instance (15 x 8 raster) covers frame-level timing.
module tb_vga_pixel_streamer;
  import vga_timing_pkg::*;

  localparam int HT  = 309;
  localparam int SHT = 15;

  logic        clk, reset, s_reset;

  logic        pix_req, pix_ack, clr_underrun, underrun;
  logic        hsync, vsync, frame_start;
  coord_x_t    req_x;
  coord_y_t    req_y;
  logic [2:0]  pix_rgb, rgb;
  logic [15:0] frame_cnt;

  logic        s_req, s_ack, s_clr, s_underrun;
  logic        s_hsync, s_vsync, s_frame_start;
  coord_x_t    s_req_x;
  coord_y_t    s_req_y;
  logic [2:0]  s_prgb, s_rgb;
  logic [15:0] s_frame_cnt;

  int total, bad, cyc;
  int drop_x, drop_y;
  bit late_mode, late_pending;

  vga_pixel_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .pix_req      (pix_req),
    .req_x        (req_x),
    .req_y        (req_y),
    .pix_ack      (pix_ack),
    .pix_rgb      (pix_rgb),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .hsync        (hsync),
    .vsync        (vsync),
    .rgb          (rgb),
    .frame_start  (frame_start),
    .frame_cnt    (frame_cnt)
  );

  vga_pixel_streamer #(
    .H_DISP (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_DISP (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_small (
    .clk          (clk),
    .reset        (s_reset),
    .pix_req      (s_req),
    .req_x        (s_req_x),
    .req_y        (s_req_y),
    .pix_ack      (s_ack),
    .pix_rgb      (s_prgb),
    .clr_underrun (s_clr),
    .underrun     (s_underrun),
    .hsync        (s_hsync),
    .vsync        (s_vsync),
    .rgb          (s_rgb),
    .frame_start  (s_frame_start),
    .frame_cnt    (s_frame_cnt)
  );

  // small instance: source always answers in the request clk with x[2:0]
  assign s_ack  = s_req;
  assign s_prgb = s_req_x[2:0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pixel source for the full-size instance
  initial begin
    pix_ack      = 1'b0;
    pix_rgb      = 3'b000;
    late_pending = 1'b0;
    forever begin
      @(negedge clk);
      pix_ack = 1'b0;
      pix_rgb = 3'b000;
      if (late_pending) begin
        pix_ack      = 1'b1;
        pix_rgb      = 3'b010;
        late_pending = 1'b0;
      end else if (pix_req === 1'b1) begin
        if (int'(req_x) == drop_x && int'(req_y) == drop_y) begin
          late_pending = late_mode;
        end else begin
          pix_ack = 1'b1;
          pix_rgb = req_x[2:0];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // negedge index (counted from reset release) at which pixel (x,y) is first shown
  function automatic int pk(input int x, input int y, input int htot);
    return 2 + 2 * (y * htot + x);
  endfunction

  initial begin
    int h, k, e_rgb, e_hs;
    total = 0; bad = 0; cyc = 0;
    drop_x = -1; drop_y = -1; late_mode = 1'b0;
    reset = 1'b0; s_reset = 1'b0; clr_underrun = 1'b0; s_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_pix_req", 32'(pix_req), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // ---------------- reduced raster: frame timing ----------------
    @(negedge clk);
    s_reset = 1'b1;
    cyc = 0;
    wait_to(1);
    check("s_fs_before", 32'(s_frame_start), 0);
    wait_to(2);
    check("s_fs_f1", 32'(s_frame_start), 1);
    check("s_cnt_f1", 32'(s_frame_cnt), 1);
    wait_to(pk(9, 0, SHT));
    check("s_hs_9", 32'(s_hsync), 1);
    wait_to(pk(10, 0, SHT));
    check("s_hs_10", 32'(s_hsync), 0);
    wait_to(pk(13, 0, SHT));
    check("s_hs_13", 32'(s_hsync), 1);
    wait_to(pk(3, 1, SHT));
    check("s_rgb_3_1", 32'(s_rgb), 3);
    wait_to(pk(9, 1, SHT));
    check("s_rgb_blank", 32'(s_rgb), 0);
    wait_to(pk(0, 4, SHT));
    check("s_vs_line4", 32'(s_vsync), 1);
    wait_to(pk(0, 5, SHT));
    check("s_vs_line5", 32'(s_vsync), 0);
    wait_to(pk(14, 6, SHT));
    check("s_vs_line6_end", 32'(s_vsync), 0);
    wait_to(pk(0, 7, SHT));
    check("s_vs_line7", 32'(s_vsync), 1);
    wait_to(pk(14, 7, SHT) + 1);
    check("s_fs_last_pix", 32'(s_frame_start), 0);
    check("s_cnt_last_pix", 32'(s_frame_cnt), 1);
    wait_to(242);
    check("s_fs_f2", 32'(s_frame_start), 1);
    check("s_cnt_f2", 32'(s_frame_cnt), 2);
    wait_to(243);
    check("s_fs_f2_pulse", 32'(s_frame_start), 0);
    wait_to(244);
    check("s_rgb_f2_x1", 32'(s_rgb), 1);
    wait_to(482);
    check("s_cnt_f3", 32'(s_frame_cnt), 3);
    check("s_underrun", 32'(s_underrun), 0);
    check("held_hsync", 32'(hsync), 1);
    check("held_pix_req", 32'(pix_req), 0);

    // ---------------- full raster ----------------
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    wait_to(1);
    check("fs_before", 32'(frame_start), 0);
    check("cnt_before", 32'(frame_cnt), 0);
    check("req_before", 32'(pix_req), 0);
    wait_to(2);
    check("fs_f1", 32'(frame_start), 1);
    check("cnt_f1", 32'(frame_cnt), 1);
    check("rgb_0_0", 32'(rgb), 0);
    check("req_first", 32'(pix_req), 1);
    check("req_x_first", 32'(req_x), 1);
    check("req_y_first", 32'(req_y), 0);
    wait_to(3);
    check("fs_pulse", 32'(frame_start), 0);
    check("req_pulse", 32'(pix_req), 0);

    // lines 0 and 1, every pixel on both of its clks
    for (int n = 1; n < 2 * HT; n++) begin
      h     = n % HT;
      e_rgb = (h < 256) ? (h & 7) : 0;
      e_hs  = (h >= 263 && h <= 285) ? 0 : 1;
      k     = 2 + 2 * n;
      wait_to(k);
      check($sformatf("line_a n=%0d", n), {29'd0, hsync, vsync, rgb}, 32'(e_hs * 16 + 8 + e_rgb));
      wait_to(k + 1);
      check($sformatf("line_b n=%0d", n), {29'd0, hsync, vsync, rgb}, 32'(e_hs * 16 + 8 + e_rgb));
    end

    // missed fetch at (10,5)
    drop_x = 10; drop_y = 5; late_mode = 1'b0;
    for (int x = 8; x <= 12; x++) begin
      wait_to(pk(x, 5, HT));
      check($sformatf("urun_rgb x=%0d", x), 32'(rgb), (x == 10) ? 7 : (x & 7));
      check($sformatf("urun_flag x=%0d", x), 32'(underrun), (x >= 10) ? 1 : 0);
      wait_to(pk(x, 5, HT) + 1);
      check($sformatf("urun_rgb_b x=%0d", x), 32'(rgb), (x == 10) ? 7 : (x & 7));
    end
    clr_underrun = 1'b1;
    wait_to(cyc + 1);
    clr_underrun = 1'b0;
    check("urun_cleared", 32'(underrun), 0);

    // ack arriving in the deadline tick clk is ignored
    drop_x = 20; drop_y = 6; late_mode = 1'b1;
    wait_to(pk(19, 6, HT));
    check("late_prev_rgb", 32'(rgb), 3);
    check("late_prev_flag", 32'(underrun), 0);
    wait_to(pk(20, 6, HT));
    check("late_rgb", 32'(rgb), 7);
    check("late_flag", 32'(underrun), 1);
    wait_to(pk(21, 6, HT));
    check("late_next_rgb", 32'(rgb), 5);
    late_mode = 1'b0;
    clr_underrun = 1'b1;
    wait_to(cyc + 1);
    clr_underrun = 1'b0;
    check("late_cleared", 32'(underrun), 0);

    // clear and a new miss on the same edge: the miss wins
    drop_x = 29; drop_y = 7;
    wait_to(pk(29, 7, HT) - 1);
    check("simul_pre", 32'(underrun), 0);
    clr_underrun = 1'b1;
    wait_to(pk(29, 7, HT));
    clr_underrun = 1'b0;
    check("simul_flag", 32'(underrun), 1);
    check("simul_rgb", 32'(rgb), 7);
    wait_to(pk(30, 7, HT));
    check("simul_next_rgb", 32'(rgb), 6);
    check("simul_sticky", 32'(underrun), 1);
    drop_x = -1; drop_y = -1;

    // asynchronous reset at (100,50)
    wait_to(pk(100, 50, HT));
    check("mid_rgb", 32'(rgb), 4);
    check("mid_cnt", 32'(frame_cnt), 1);
    #1 reset = 1'b0;
    #1;
    check("mrst_hsync", 32'(hsync), 1);
    check("mrst_vsync", 32'(vsync), 1);
    check("mrst_rgb", 32'(rgb), 0);
    check("mrst_underrun", 32'(underrun), 0);
    check("mrst_cnt", 32'(frame_cnt), 0);
    repeat (3) @(negedge clk);
    check("mrst_req", 32'(pix_req), 0);
    reset = 1'b1;
    cyc = 0;
    wait_to(1);
    check("rel_fs_before", 32'(frame_start), 0);
    check("rel_cnt_before", 32'(frame_cnt), 0);
    wait_to(2);
    check("rel_fs", 32'(frame_start), 1);
    check("rel_cnt", 32'(frame_cnt), 1);
    check("rel_req_x", 32'(req_x), 1);
    check("rel_req_y", 32'(req_y), 0);
    wait_to(4);
    check("rel_rgb_x1", 32'(rgb), 1);
    wait_to(6);
    check("rel_rgb_x2", 32'(rgb), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
